wb_stage: RTL

- Write-back stage of the 5-stage RISC-V pipeline. It sits between the MEM stage and the ID-stage register file.
- Accepts one retiring instruction per handshake and waits for the data-memory response on loads.
- Sign/zero-extends load data and drives the register-file write port (wen, rd, rd_v).
- Holds the upstream stage (in_ready low) while a load response is outstanding.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/load_ext.sv | 30 +++
 rtl/wb_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath widths, load funct3 encodings
// and the write-back stage state encoding.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        WB_IDLE     = 1'b0,
        WB_WAIT_RSP = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_ext.sv
// Combinational load-data aligner: picks the byte/half addressed by addr_lo
// out of an aligned word and sign- or zero-extends it according to funct3.
module load_ext #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] ext_v
);
    import riscv_pkg::*;

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select, then extension; unknown encodings fall back to a full word.
    always_comb begin
        byte_s = data[8*addr_lo +: 8];
        half_s = data[16*addr_lo[1] +: 16];
        case (funct3)
            F3_LB:   ext_v = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LH:   ext_v = {{(XLEN-16){half_s[15]}}, half_s};
            F3_LBU:  ext_v = {{(XLEN-8){1'b0}}, byte_s};
            F3_LHU:  ext_v = {{(XLEN-16){1'b0}}, half_s};
            F3_LW:   ext_v = data;
            default: ext_v = data;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results in one cycle, waits (bounded) for the
// data-memory response on loads. Optional WB_BYPASS_EN adds a write->ID bypass.
module wb_stage #(
    parameter int XLEN        = riscv_pkg::XLEN,
    parameter int REG_AW      = riscv_pkg::REG_AW,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wen,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_alu_v,
    input  logic              in_is_load,
    input  logic [2:0]        in_ld_funct3,
    input  logic [1:0]        in_addr_lo,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rsp_data,
    output logic              wen,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   rd_v,
    output logic              ld_timeout
`ifdef WB_BYPASS_EN
    ,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [XLEN-1:0]   id_rs1_rf,
    input  logic [XLEN-1:0]   id_rs2_rf,
    output logic [XLEN-1:0]   id_rs1_v,
    output logic [XLEN-1:0]   id_rs2_v
`endif
);
    import riscv_pkg::*;

    localparam int CW = $clog2(RSP_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RSP_TIMEOUT - 1);

    wb_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
    logic              ld_wen_q, ld_wen_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [1:0]        ld_alo_q, ld_alo_d;
    logic              wen_q, wen_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   rd_v_q, rd_v_d;
    logic              ld_timeout_q, ld_timeout_d;
    logic [XLEN-1:0]   ext_v_s;

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .funct3  (ld_f3_q),
        .addr_lo (ld_alo_q),
        .data    (dmem_rsp_data),
        .ext_v   (ext_v_s)
    );

    assign in_ready   = (state_q == WB_IDLE);
    assign wen        = wen_q;
    assign rd         = rd_q;
    assign rd_v       = rd_v_q;
    assign ld_timeout = ld_timeout_q;

    // Next-state and output computation; wen/ld_timeout default low so they pulse.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ld_rd_d      = ld_rd_q;
        ld_wen_d     = ld_wen_q;
        ld_f3_d      = ld_f3_q;
        ld_alo_d     = ld_alo_q;
        wen_d        = 1'b0;
        rd_d         = rd_q;
        rd_v_d       = rd_v_q;
        ld_timeout_d = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (in_valid && in_is_load) begin
                    ld_rd_d  = in_rd;
                    ld_wen_d = in_wen;
                    ld_f3_d  = in_ld_funct3;
                    ld_alo_d = in_addr_lo;
                    cnt_d    = '0;
                    state_d  = WB_WAIT_RSP;
                end else if (in_valid) begin
                    wen_d  = in_wen && (in_rd != '0);
                    rd_d   = in_rd;
                    rd_v_d = in_alu_v;
                end else begin
                    state_d = WB_IDLE;
                end
            end
            WB_WAIT_RSP: begin
                // A response on the final wait cycle takes priority over the timeout.
                if (dmem_rsp_valid) begin
                    wen_d   = ld_wen_q && (ld_rd_q != '0);
                    rd_d    = ld_rd_q;
                    rd_v_d  = ext_v_s;
                    cnt_d   = '0;
                    state_d = WB_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    ld_timeout_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = WB_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = WB_IDLE;
            end
        endcase
    end

    // State, load context and registered write-port outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WB_IDLE;
            cnt_q        <= '0;
            ld_rd_q      <= '0;
            ld_wen_q     <= 1'b0;
            ld_f3_q      <= 3'b000;
            ld_alo_q     <= 2'b00;
            wen_q        <= 1'b0;
            rd_q         <= '0;
            rd_v_q       <= '0;
            ld_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ld_rd_q      <= ld_rd_d;
            ld_wen_q     <= ld_wen_d;
            ld_f3_q      <= ld_f3_d;
            ld_alo_q     <= ld_alo_d;
            wen_q        <= wen_d;
            rd_q         <= rd_d;
            rd_v_q       <= rd_v_d;
            ld_timeout_q <= ld_timeout_d;
        end
    end

`ifdef WB_BYPASS_EN
    // Same-cycle write/read bypass so ID never sees the stale register value.
    always_comb begin
        if (wen_q && (rd_q == id_rs1) && (id_rs1 != '0)) begin
            id_rs1_v = rd_v_q;
        end else begin
            id_rs1_v = id_rs1_rf;
        end
        if (wen_q && (rd_q == id_rs2) && (id_rs2 != '0)) begin
            id_rs2_v = rd_v_q;
        end else begin
            id_rs2_v = id_rs2_rf;
        end
    end
`endif

endmodule
